dsc_mul_4in: RTL and testbench
==============================

// Module: dsc_mul_4in
// PURPOSE
// - Exact 4-operand unsigned multiplier built on deterministic stochastic computing (DSC).
// - Each operand is converted to a unary bit-stream by comparing it against one digit of a sweep counter.
// - The four streams are ANDed, and the ones are counted back to binary.
// - A naive exhaustive sweep covers all 2^(4*WIDTH) digit combinations, so z equals a*b*c*d exactly.
// - Ports are named dsc_mul to match the existing bench instantiation.
// PARAMETERS
// - WIDTH  4  bits per operand; the sweep is 4*WIDTH bits; z is 4*WIDTH bits.
// PORTS
// - clk  in   1        single clock; all state updates on the rising edge.
// - rst  in   1        synchronous, active-high reset.
// - en   in   1        advance enable; when low, all state holds.
// - a    in   WIDTH    operand 0, unsigned.
// - b    in   WIDTH    operand 1, unsigned.
// - c    in   WIDTH    operand 2, unsigned.
// - d    in   WIDTH    operand 3, unsigned.
// - z    out  4*WIDTH  product accumulator (registered).
// - ov   out  1        operation finished (registered, sticky).
// BEHAVIOUR
// - Reset: synchronous, active-high; rst has priority over en.
//   - On a rst edge: sweep S<=0, z<=0, ov<=0.
//   - rst asserted mid-operation aborts and clears; no partial result is kept.
// - Sweep counter S, 4*WIDTH bits, split into digits:
//   - dA = S[WIDTH-1:0] (fastest).
//   - dB = next WIDTH bits.
//   - dC = next WIDTH bits.
//   - dD = top WIDTH bits (slowest).
//   - Carry chaining is single-clock enable logic; no derived or ripple clocks.
// - Stream bits (combinational): sA=(a>dA), sB=(b>dB), sC=(c>dC), sD=(d>dD); p = sA&sB&sC&sD.
//   - Over one full digit period, operand x yields exactly x ones.
// - Each edge with en=1, rst=0, ov=0:
//   - z <= z + p.
//   - S <= S + 1.
//   - If S == all-ones, then ov <= 1 on that edge, and S wraps to 0.
// - Latency: exactly 2^(4*WIDTH) enabled cycles (65536 for WIDTH=4) from reset release to ov high.
//   - ov becomes visible after the edge that consumed S=all-ones; z is final in the same cycle ov rises.
// - Once ov=1:
//   - z and S freeze regardless of en.
//   - ov stays high until rst.
//   - A new operation requires rst.
// - en=0 pauses: S, z and ov hold; the sweep resumes seamlessly, so total enabled cycles is unchanged.
// - Operands are sampled combinationally every cycle and must be held stable while en=1 and ov=0.
//   - Changing an operand mid-sweep gives an undefined (but non-overflowing) z.
// - Width rule: max z = (2^WIDTH-1)^4 = 50625 for WIDTH=4, which fits in 4*WIDTH bits.
//   - z never wraps; z <= 2^(4*WIDTH) - 1 always.
// - Zero operand: its stream is all zeros, so z stays 0; ov timing is unchanged.
// - Suggested structure: a generic counter submodule (WIDTH, en, out, overflow) for S and for z, plus comparators and control.
// TESTING
// - rst 2 cycles, then a=b=c=d=15, en=1 -> ov rises after exactly 65536 enabled cycles; z=50625.
// - a=5,b=3,c=7,d=2 -> z=210 at ov; hold en 10 more cycles -> z stays 210, ov stays 1.
// - a=0,b=15,c=15,d=15 -> z=0, ov after 65536 cycles; also a=b=c=d=1 -> z=1.
// - a=9,b=4,c=11,d=6, with en dropped for 100 cycles mid-sweep -> z=2376; ov after 65636 total cycles.
// - Assert rst at cycle 30000 mid-op -> next cycle z=0, ov=0; restart with a=2,b=2,c=2,d=2 -> z=16 after 65536 cycles.
// - Random 100 operand sets, rst between tests -> z == a*b*c*d every time; every test takes 65536 cycles.

Source files
------------

// File: rtl/dsc_mul_if.sv
// Operand/result bundle for the DSC 4-operand multiplier.
// Latency: none, wires only.
// Backpressure: none; en is the only flow control and operands must hold while en=1 and ov=0.
// Ports: en/a/b/c/d driven by master, z/ov driven by slave.
interface dsc_mul_if #(
    parameter int WIDTH = 4
);
    logic               en;
    logic [WIDTH-1:0]   a;
    logic [WIDTH-1:0]   b;
    logic [WIDTH-1:0]   c;
    logic [WIDTH-1:0]   d;
    logic [4*WIDTH-1:0] z;
    logic               ov;

    modport master (
        output en, a, b, c, d,
        input  z, ov
    );

    modport slave (
        input  en, a, b, c, d,
        output z, ov
    );
endinterface

// File: rtl/dsc_mul_4in.sv
// Exact unsigned a*b*c*d via deterministic stochastic computing: unary streams ANDed and counted.
// Latency: 2^(4*WIDTH) enabled cycles from reset release to ov; z is final when ov rises.
// Backpressure: en=0 pauses everything; once ov=1 state freezes until rst.
// Ports: clk, rst (sync, active-high), dsc_mul (slave: en, a..d in; z, ov out).

// Sweep counter: increments when inc=1, flags the edge on which it wraps from all-ones.
module dsc_cnt #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] q,
    output logic         wrap
);
    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (inc) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign q    = cnt_q;
    assign wrap = inc & (&cnt_q);
endmodule

module dsc_mul_4in #(
    parameter int WIDTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    dsc_mul_if.slave   dsc_mul
);
    localparam int SW = 4 * WIDTH;

    logic [SW-1:0]    s;
    logic             s_wrap;
    logic             adv;
    logic [WIDTH-1:0] dig_a;
    logic [WIDTH-1:0] dig_b;
    logic [WIDTH-1:0] dig_c;
    logic [WIDTH-1:0] dig_d;
    logic             p;
    logic [SW-1:0]    z_q;
    logic [SW-1:0]    z_d;
    logic             ov_q;
    logic             ov_d;

    // The sweep only advances while enabled and not yet finished; this single
    // enable feeds every register so S, z and ov freeze together.
    assign adv = dsc_mul.en & ~ov_q;

    dsc_cnt #(.W(SW)) u_sweep (
        .clk  (clk),
        .rst  (rst),
        .inc  (adv),
        .q    (s),
        .wrap (s_wrap)
    );

    // Digit A is the fastest-moving slice, digit D the slowest; together the
    // full sweep visits every digit combination exactly once.
    assign dig_a = s[WIDTH-1:0];
    assign dig_b = s[2*WIDTH-1:WIDTH];
    assign dig_c = s[3*WIDTH-1:2*WIDTH];
    assign dig_d = s[4*WIDTH-1:3*WIDTH];

    // Operand x exceeds exactly x digit values per period, giving x ones.
    assign p = (dsc_mul.a > dig_a) & (dsc_mul.b > dig_b) &
               (dsc_mul.c > dig_c) & (dsc_mul.d > dig_d);

    always_comb begin
        z_d  = z_q;
        ov_d = ov_q | s_wrap;
        if (adv && p) begin
            // Cannot wrap: the count of ones is at most (2^WIDTH-1)^4.
            z_d = z_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            z_q  <= '0;
            ov_q <= 1'b0;
        end else begin
            z_q  <= z_d;
            ov_q <= ov_d;
        end
    end

    assign dsc_mul.z  = z_q;
    assign dsc_mul.ov = ov_q;
endmodule

// File: tb/tb_dsc_mul_4in.sv
module tb_dsc_mul_4in;
    logic clk;
    logic rst4;
    logic rst2;
    int   checks;
    int   errors;

    dsc_mul_if #(.WIDTH(4)) if4 ();
    dsc_mul_if #(.WIDTH(2)) if2 ();

    dsc_mul_4in #(.WIDTH(4)) dut4 (.clk(clk), .rst(rst4), .dsc_mul(if4));
    dsc_mul_4in #(.WIDTH(2)) dut2 (.clk(clk), .rst(rst2), .dsc_mul(if2));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Full operation on the WIDTH=2 instance; reference product is plain a*b*c*d
    // and the expected latency is 4^4 = 256 enabled cycles.
    task automatic op2(input int a, input int b, input int c, input int d,
                       input int pause_at, input int pause_len, input string tag);
        int cyc;
        int prod;
        logic [7:0] zs;
        prod = a * b * c * d;
        rst2 = 1'b1;
        if2.en = 1'b0;
        step();
        step();
        chk({tag, "_rst_z"}, 32'(if2.z), 0);
        chk({tag, "_rst_ov"}, 32'(if2.ov), 0);
        rst2 = 1'b0;
        if2.a = 2'(a); if2.b = 2'(b); if2.c = 2'(c); if2.d = 2'(d);
        if2.en = 1'b1;
        cyc = 0;
        while (!if2.ov && cyc < 1000) begin
            if (pause_len > 0 && cyc == pause_at) begin
                if2.en = 1'b0;
                zs = if2.z;
                repeat (pause_len) step();
                chk({tag, "_pause_z"}, 32'(if2.z), 32'(zs));
                chk({tag, "_pause_ov"}, 32'(if2.ov), 0);
                if2.en = 1'b1;
            end
            step();
            cyc++;
        end
        chk({tag, "_lat"}, cyc, 256);
        chk({tag, "_z"}, 32'(if2.z), prod);
        chk({tag, "_ov"}, 32'(if2.ov), 1);
    endtask

    initial begin
        int cyc;
        logic [15:0] zs;
        checks = 0;
        errors = 0;
        rst4 = 1'b1; rst2 = 1'b1;
        if4.en = 1'b0; if4.a = '0; if4.b = '0; if4.c = '0; if4.d = '0;
        if2.en = 1'b0; if2.a = '0; if2.b = '0; if2.c = '0; if2.d = '0;
        step();
        step();
        chk("w4_rst_z", 32'(if4.z), 0);
        chk("w4_rst_ov", 32'(if4.ov), 0);

        // WIDTH=4 full sweep, all operands 15, with a 100-cycle pause mid-sweep.
        rst4 = 1'b0;
        if4.a = 4'd15; if4.b = 4'd15; if4.c = 4'd15; if4.d = 4'd15;
        if4.en = 1'b1;
        cyc = 0;
        while (!if4.ov && cyc < 70000) begin
            if (cyc == 30000) begin
                if4.en = 1'b0;
                zs = if4.z;
                repeat (100) step();
                chk("w4_pause_z", 32'(if4.z), 32'(zs));
                chk("w4_pause_ov", 32'(if4.ov), 0);
                if4.en = 1'b1;
            end
            step();
            cyc++;
        end
        chk("w4_lat", cyc, 65536);
        chk("w4_z", 32'(if4.z), 50625);
        chk("w4_ov", 32'(if4.ov), 1);
        repeat (10) step();
        chk("w4_hold_z", 32'(if4.z), 50625);
        chk("w4_hold_ov", 32'(if4.ov), 1);
        if4.en = 1'b0;
        rst4 = 1'b1;
        step();
        chk("w4_rerst_z", 32'(if4.z), 0);
        chk("w4_rerst_ov", 32'(if4.ov), 0);

        // WIDTH=2 directed cases.
        op2(3, 3, 3, 3, 0, 0, "max");
        repeat (10) step();
        chk("max_hold_z", 32'(if2.z), 81);
        chk("max_hold_ov", 32'(if2.ov), 1);
        op2(0, 3, 3, 3, 0, 0, "zero");
        op2(1, 1, 1, 1, 0, 0, "ones");
        op2(2, 1, 3, 2, 100, 20, "pause");
        op2(3, 2, 1, 3, 0, 0, "mix");

        // Abort mid-operation, then restart.
        rst2 = 1'b1;
        step();
        step();
        rst2 = 1'b0;
        if2.a = 2'd3; if2.b = 2'd3; if2.c = 2'd3; if2.d = 2'd3;
        if2.en = 1'b1;
        repeat (200) step();
        rst2 = 1'b1;
        step();
        chk("abort_z", 32'(if2.z), 0);
        chk("abort_ov", 32'(if2.ov), 0);
        op2(2, 2, 2, 2, 0, 0, "restart");

        // Random operand sets.
        for (int i = 0; i < 30; i++) begin
            op2(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                int'($urandom_range(1, 250)), int'($urandom_range(0, 3)), "rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
